// File: rtl/ddc_edid_reader.sv
// ddc_edid_reader: I2C master on the HDMI DDC bus. It reads the base EDID
// block (EDID_BYTES bytes starting at offset 0) from device 0xA0/0xA1 and
// streams each byte out together with its index.
//
// Ports
//   clk_50m     : sole clock (CLK_HZ)
//   reset       : synchronous, active-high
//   start       : one-cycle request, ignored while busy
//   hpd         : hot-plug detect (synchronised); low aborts a transaction
//   scl_in      : SCL pad level (synchronised)
//   sda_in      : SDA pad level (synchronised)
//   scl_oe      : 1 pulls SCL low (open drain)
//   sda_oe      : 1 pulls SDA low (open drain)
//   busy        : transaction in progress
//   edid_data   : received byte
//   edid_addr   : index of edid_data
//   edid_valid  : one-cycle strobe for edid_data/edid_addr
//   done        : one-cycle strobe at transaction end (success or failure)
//   error       : sticky failure flag, cleared by an accepted start
//   checksum_ok : only with DDC_CHECKSUM_EN; 1 iff the byte sum is 0 and no error
//
// Build option: define DDC_CHECKSUM_EN to add the checksum accumulator and
// the checksum_ok port.
//
// Every state lasts 4 quarters of QDIV cycles. SCL is released in quarter 1
// of every state, where a sink may stretch the clock.

module ddc_edid_reader #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SCL_HZ     = 100_000,
  parameter int unsigned EDID_BYTES = 128
) (
  input  logic       clk_50m,
  input  logic       reset,
  input  logic       start,
  input  logic       hpd,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic [7:0] edid_data,
  output logic [7:0] edid_addr,
  output logic       edid_valid,
  output logic       done,
`ifdef DDC_CHECKSUM_EN
  output logic       checksum_ok,
`endif
  output logic       error
);

  localparam int unsigned     QDIV        = CLK_HZ / (4 * SCL_HZ);
  localparam int unsigned     QW          = (QDIV > 1) ? $clog2(QDIV) : 1;
  // Clock-stretch timeout: 65536 quarters measured in clk cycles.
  localparam longint unsigned STALL_LIMIT = 64'd65536 * QDIV;
  localparam int unsigned     SW          = $clog2(STALL_LIMIT);
  localparam logic [7:0]      LAST_IDX    = 8'(EDID_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_W, S_OFFSET, S_ACK_O,
    S_RSTART, S_ADDR_R, S_ACK_R, S_READ, S_MACK, S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          rx_q, rx_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic qend, hold;
  assign qend = (qcnt_q == QW'(QDIV - 1));
  // Stretch: hold at the very start of quarter 1 so that SCL gets a full
  // quarter 1 plus quarter 2 of high time after the sink lets go.
  assign hold = (phase_q == 2'd1) && (qcnt_q == '0) && !scl_in;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    qcnt_d  = qcnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    stall_d = '0;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    error_d = error_q;

    if (state_q == S_IDLE) begin
      phase_d = 2'd0;
      qcnt_d  = '0;
      // A start in the same cycle as done is dropped.
      if (start && !done_q) begin
        if (hpd) begin
          state_d = S_START;
          error_d = 1'b0;
        end else begin
          error_d = 1'b1;
          done_d  = 1'b1;
        end
      end
    end else if (!hpd) begin
      // Sink unplugged: drop the bus immediately, no STOP.
      state_d = S_IDLE;
      phase_d = 2'd0;
      qcnt_d  = '0;
      addr_d  = 8'd0;
      error_d = 1'b1;
      done_d  = 1'b1;
    end else if (hold) begin
      stall_d = stall_q + SW'(1);
      if (stall_q == SW'(STALL_LIMIT - 1)) begin
        state_d = S_IDLE;
        phase_d = 2'd0;
        addr_d  = 8'd0;
        error_d = 1'b1;
        done_d  = 1'b1;
      end
    end else begin
      qcnt_d = qend ? '0 : qcnt_q + QW'(1);
      if (qend) phase_d = phase_q + 2'd1;

      // Sample SDA on the last cycle of quarter 2.
      if (qend && phase_q == 2'd2) begin
        rx_d = sda_in;
        if (state_q == S_READ) begin
          sh_d = {sh_q[6:0], sda_in};
          if (bit_q == 3'd7) begin
            data_d  = {sh_q[6:0], sda_in};
            valid_d = 1'b1;
          end
        end
      end

      // Frame end: last cycle of quarter 3.
      if (qend && phase_q == 2'd3) begin
        unique case (state_q)
          S_START: begin
            state_d = S_ADDR_W;
            sh_d    = 8'hA0;
            bit_d   = 3'd0;
          end
          S_ADDR_W, S_OFFSET, S_ADDR_R: begin
            if (bit_q == 3'd7) begin
              bit_d = 3'd0;
              if (state_q == S_ADDR_W)      state_d = S_ACK_W;
              else if (state_q == S_OFFSET) state_d = S_ACK_O;
              else                          state_d = S_ACK_R;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
          S_ACK_W: begin
            if (rx_q) begin
              state_d = S_STOP;
              error_d = 1'b1;
            end else begin
              state_d = S_OFFSET;
              sh_d    = 8'h00;
            end
          end
          S_ACK_O: begin
            if (rx_q) begin
              state_d = S_STOP;
              error_d = 1'b1;
            end else begin
              state_d = S_RSTART;
            end
          end
          S_RSTART: begin
            state_d = S_ADDR_R;
            sh_d    = 8'hA1;
            bit_d   = 3'd0;
          end
          S_ACK_R: begin
            if (rx_q) begin
              state_d = S_STOP;
              error_d = 1'b1;
            end else begin
              state_d = S_READ;
              bit_d   = 3'd0;
            end
          end
          S_READ: begin
            if (bit_q == 3'd7) begin
              state_d = S_MACK;
              bit_d   = 3'd0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          S_MACK: begin
            if (addr_q == LAST_IDX) begin
              state_d = S_STOP;
            end else begin
              state_d = S_READ;
              addr_d  = addr_q + 8'd1;
            end
          end
          S_STOP: begin
            state_d = S_IDLE;
            addr_d  = 8'd0;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Line drive decoded from the registered state. Bit frames pull SCL low in
  // quarters 0 and 3; START/RSTART/STOP shape their own edges.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        scl_oe = (phase_q == 2'd3);
        sda_oe = phase_q[1];
      end
      S_RSTART: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = phase_q[1];
      end
      S_STOP: begin
        scl_oe = (phase_q == 2'd0);
        sda_oe = (phase_q != 2'd3);
      end
      S_ADDR_W, S_OFFSET, S_ADDR_R: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = !sh_q[7];
      end
      S_MACK: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
        sda_oe = (addr_q != LAST_IDX);
      end
      default: begin
        scl_oe = (phase_q == 2'd0) || (phase_q == 2'd3);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      qcnt_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      rx_q    <= 1'b0;
      stall_q <= '0;
      data_q  <= 8'd0;
      addr_q  <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      qcnt_q  <= qcnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      stall_q <= stall_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

`ifdef DDC_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       ck_q, ck_d;

  always_comb begin
    sum_d = sum_q;
    ck_d  = ck_q;
    if (state_q == S_IDLE && start && !done_q) begin
      sum_d = 8'd0;
      ck_d  = 1'b0;
    end
    if (valid_d) sum_d = sum_q + data_d;
    // valid_d and done_d are never both set, so sum_q is final here.
    if (done_d) ck_d = (sum_q == 8'd0) && !error_d;
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      sum_q <= 8'd0;
      ck_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ck_q  <= ck_d;
    end
  end

  assign checksum_ok = ck_q;
`endif

  assign busy       = (state_q != S_IDLE);
  assign edid_data  = data_q;
  assign edid_addr  = addr_q;
  assign edid_valid = valid_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ddc_edid_reader.sv
// Testbench for ddc_edid_reader: behavioural EDID sink on a wired-AND bus,
// scenario table plus hand-written abort/reset sequences, and a scoreboard
// of expected {data, addr} pairs popped on every edid_valid.
module tb_ddc_edid_reader;

  localparam int unsigned CLK_HZ      = 1_200_000;
  localparam int unsigned SCL_HZ      = 100_000;
  localparam int unsigned EDID_BYTES  = 128;
  localparam int unsigned QDIV        = CLK_HZ / (4 * SCL_HZ);
  localparam int unsigned FULL_CYCLES = (4 + 36 * 3 + 4 + 36 * EDID_BYTES + 4) * QDIV;
  localparam int unsigned NACK_CYCLES = (4 + 36 + 4) * QDIV;
  localparam int          LIMIT       = 40000;

  logic       clk_50m = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       hpd = 1'b1;
  logic       scl_oe, sda_oe, busy, edid_valid, done, error;
  logic [7:0] edid_data, edid_addr;
`ifdef DDC_CHECKSUM_EN
  logic       checksum_ok;
`endif

  logic s_scl_low = 1'b0;
  logic s_sda_low = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = ~(scl_oe | s_scl_low);
  assign sda_line = ~(sda_oe | s_sda_low);

  ddc_edid_reader #(.CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .EDID_BYTES(EDID_BYTES)) dut (
    .clk_50m    (clk_50m),
    .reset      (reset),
    .start      (start),
    .hpd        (hpd),
    .scl_in     (scl_line),
    .sda_in     (sda_line),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .edid_data  (edid_data),
    .edid_addr  (edid_addr),
    .edid_valid (edid_valid),
    .done       (done),
`ifdef DDC_CHECKSUM_EN
    .checksum_ok(checksum_ok),
`endif
    .error      (error)
  );

  always #5 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- EDID sink model ----------------
  logic [7:0] mem [0:255];
  logic       cfg_nack = 1'b0;
  logic       cfg_stretch = 1'b0;
  int         s_mode = 0;   // 0 idle, 1 receiving, 2 transmitting
  int         s_cnt = 0;    // SCL rises seen in the current 9-bit frame
  logic [7:0] s_sr = 8'd0, s_tx = 8'd0, s_ptr = 8'd0, s_byte = 8'd0;
  logic       s_first = 1'b0, s_is_read = 1'b0, s_mack = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         s_stretch = 0;

  always @(posedge clk_50m) begin
    scl_p <= scl_line;
    sda_p <= sda_line;
    if (reset || !hpd) begin
      s_mode    <= 0;
      s_sda_low <= 1'b0;
      s_scl_low <= 1'b0;
      s_stretch <= 0;
    end else begin
      if (s_stretch != 0) begin
        s_stretch <= s_stretch - 1;
        if (s_stretch == 1) s_scl_low <= 1'b0;
      end
      if (scl_line && scl_p && sda_p && !sda_line) begin
        s_mode <= 1; s_cnt <= 0; s_first <= 1'b1; s_sda_low <= 1'b0;
      end else if (scl_line && scl_p && !sda_p && sda_line) begin
        s_mode <= 0; s_sda_low <= 1'b0;
      end else if (s_mode != 0 && scl_line && !scl_p) begin
        if (s_cnt < 8) begin
          if (s_mode == 1) s_sr <= {s_sr[6:0], sda_line};
          s_cnt <= s_cnt + 1;
        end else begin
          s_cnt <= 9;
          if (s_mode == 2) s_mack <= !sda_line;
        end
      end else if (s_mode != 0 && !scl_line && scl_p) begin
        if (s_cnt == 9) begin
          s_cnt <= 0;
          if ((s_mode == 1 && s_is_read) || (s_mode == 2 && s_mack)) begin
            s_mode    <= 2;
            s_tx      <= mem[s_ptr];
            s_byte    <= s_ptr;
            s_sda_low <= !mem[s_ptr][7];
            s_ptr     <= s_ptr + 8'd1;
          end else begin
            if (s_mode == 2) s_mode <= 0;
            s_sda_low <= 1'b0;
          end
        end else if (s_cnt == 8) begin
          if (s_mode == 1) begin
            if (s_first && s_sr == 8'hA0 && cfg_nack) begin
              s_mode <= 0; s_sda_low <= 1'b0;
            end else begin
              s_sda_low <= 1'b1;
              if (s_first) begin s_is_read <= s_sr[0]; s_first <= 1'b0; end
              else s_ptr <= s_sr;
            end
          end else begin
            s_sda_low <= 1'b0;
          end
        end else if (s_mode == 2) begin
          s_sda_low <= !s_tx[3'(7 - s_cnt)];
          if (cfg_stretch && s_byte == 8'd5 && s_cnt == 3) begin
            s_scl_low <= 1'b1;
            s_stretch <= 1000;
          end
        end
      end
    end
  end

  // ---------------- monitor + scoreboard ----------------
  typedef struct packed { logic [7:0] data; logic [7:0] addr; } exp_t;
  exp_t sb[$];

  int   valid_total = 0, stops_total = 0, act_total = 0, stretch_high = 0, hi = 0;
  logic meas = 1'b0, mon_low_p = 1'b0, mon_scl_p = 1'b1, mon_sda_p = 1'b1;

  always @(negedge clk_50m) begin
    if (scl_oe || sda_oe) act_total <= act_total + 1;
    if (scl_line && mon_scl_p && !mon_sda_p && sda_line) stops_total <= stops_total + 1;
    mon_scl_p <= scl_line;
    mon_sda_p <= sda_line;
    mon_low_p <= s_scl_low;
    if (mon_low_p && !s_scl_low) begin
      meas <= 1'b1;
      hi   <= scl_line ? 1 : 0;
    end else if (meas) begin
      if (scl_line) hi <= hi + 1;
      else begin stretch_high <= hi; meas <= 1'b0; end
    end
    if (edid_valid) begin
      exp_t e;
      valid_total <= valid_total + 1;
      check("valid_done_overlap", done, 0);
      if (sb.size() == 0) begin
        check("unexpected_valid_addr", {24'd0, edid_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("edid_data", edid_data, e.data);
        check("edid_addr", edid_addr, e.addr);
      end
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    logic hpd, nack, stretch, extra_start;
    int   exp_bytes, exp_err, exp_stops, exp_act, exp_lat, exp_busy, exp_ck;
  } txn_t;
  txn_t vec [4];

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{data: mem[i], addr: 8'(i)});
  endtask

  task automatic run_txn(input txn_t t);
    int   v0, s0, a0, lat, busy_cyc;
    logic seen;
    cfg_nack    = t.nack;
    cfg_stretch = t.stretch;
    hpd         = t.hpd;
    push_expected(t.exp_bytes);
    @(negedge clk_50m);
    v0 = valid_total; s0 = stops_total; a0 = act_total;
    start = 1'b1;
    lat = 0; busy_cyc = 0; seen = 1'b0;
    while (lat < LIMIT) begin
      @(negedge clk_50m);
      lat++;
      start = t.extra_start && (lat == 500);
      if (busy) busy_cyc++;
      if (done) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (t.exp_lat != 0)  check("done_latency", lat, t.exp_lat);
    if (t.exp_busy != 0) check("busy_cycles", busy_cyc, t.exp_busy);
    check("busy_at_done", busy, 0);
    check("error", error, t.exp_err);
    check("valid_count", valid_total - v0, t.exp_bytes);
    check("stop_count", stops_total - s0, t.exp_stops);
    check("bus_activity", (act_total - a0) != 0, t.exp_act);
    check("scoreboard_empty", sb.size(), 0);
    if (t.stretch) check("stretch_high_ge_2q", stretch_high >= int'(2 * QDIV), 1);
`ifdef DDC_CHECKSUM_EN
    check("checksum_ok", checksum_ok, t.exp_ck);
`endif
    @(negedge clk_50m);
    check("done_one_cycle", done, 0);
    check("addr_idle", edid_addr, 0);
    sb.delete();
  endtask

  task automatic wait_valid_addr(input logic [7:0] a, input string name);
    int n = 0;
    while (!(edid_valid && edid_addr == a) && n < LIMIT) begin
      @(negedge clk_50m);
      n++;
    end
    check(name, n < LIMIT, 1);
  endtask

  initial begin
    logic [7:0] acc;
    mem[0] = 8'h00;
    mem[1] = 8'hFF;
    acc = 8'hFF;
    for (int i = 2; i < EDID_BYTES - 1; i++) begin
      mem[i] = 8'((i * 73 + 11) & 8'hFF);
      acc    = acc + mem[i];
    end
    mem[EDID_BYTES - 1] = 8'd0 - acc;
    for (int i = EDID_BYTES; i < 256; i++) mem[i] = 8'h00;

    vec[0] = '{hpd:1, nack:0, stretch:0, extra_start:1, exp_bytes:128, exp_err:0,
               exp_stops:1, exp_act:1, exp_lat:0, exp_busy:FULL_CYCLES, exp_ck:1};
    vec[1] = '{hpd:1, nack:1, stretch:0, extra_start:0, exp_bytes:0, exp_err:1,
               exp_stops:1, exp_act:1, exp_lat:0, exp_busy:NACK_CYCLES, exp_ck:0};
    vec[2] = '{hpd:1, nack:0, stretch:1, extra_start:0, exp_bytes:128, exp_err:0,
               exp_stops:1, exp_act:1, exp_lat:0, exp_busy:0, exp_ck:1};
    vec[3] = '{hpd:0, nack:0, stretch:0, extra_start:0, exp_bytes:0, exp_err:1,
               exp_stops:0, exp_act:0, exp_lat:1, exp_busy:0, exp_ck:0};

    // Reset state
    repeat (3) @(negedge clk_50m);
    reset = 1'b0;
    @(negedge clk_50m);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", edid_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_data", edid_data, 0);
    check("rst_addr", edid_addr, 0);

    for (int i = 0; i < 4; i++) run_txn(vec[i]);

    // hpd drops during byte 40
    hpd = 1'b1; cfg_nack = 1'b0; cfg_stretch = 1'b0;
    push_expected(40);
    @(negedge clk_50m);
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    wait_valid_addr(8'd39, "reach_byte39");
    repeat (20) @(negedge clk_50m);
    hpd = 1'b0;
    @(negedge clk_50m);
    check("abort_scl_oe", scl_oe, 0);
    check("abort_sda_oe", sda_oe, 0);
    check("abort_done", done, 1);
    check("abort_error", error, 1);
    check("abort_busy", busy, 0);
    check("abort_addr", edid_addr, 0);
    check("abort_sb_empty", sb.size(), 0);
    sb.delete();
    hpd = 1'b1;
    repeat (2) @(negedge clk_50m);
    vec[0].extra_start = 1'b0;
    run_txn(vec[0]);

    // reset in the middle of READ
    push_expected(11);
    @(negedge clk_50m);
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
    wait_valid_addr(8'd10, "reach_byte10");
    repeat (7) @(negedge clk_50m);
    reset = 1'b1;
    @(negedge clk_50m);
    check("mrst_scl_oe", scl_oe, 0);
    check("mrst_sda_oe", sda_oe, 0);
    check("mrst_busy", busy, 0);
    check("mrst_valid", edid_valid, 0);
    check("mrst_done", done, 0);
    check("mrst_error", error, 0);
    check("mrst_data", edid_data, 0);
    check("mrst_addr", edid_addr, 0);
`ifdef DDC_CHECKSUM_EN
    check("mrst_checksum_ok", checksum_ok, 0);
`endif
    check("mrst_sb_empty", sb.size(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_50m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
